// File: rtl/rc_pkg.sv
// Shared definitions for the RC input blocks.
//   PW_STUCK_LOW / PW_STUCK_HIGH : codes reported for a dead input
//   PW_MID                       : servo midpoint used downstream
//   TICK_DIV_DEF                 : default system clocks per measurement tick
//   state_e                      : pulse meter FSM states
package rc_pkg;
  localparam logic [15:0] PW_STUCK_LOW  = 16'h0000;
  localparam logic [15:0] PW_STUCK_HIGH = 16'hFFFF;
  localparam logic [15:0] PW_MID        = 16'h0235;
  localparam int          TICK_DIV_DEF  = 21;

  typedef enum logic [1:0] {SYNC, LOW, HIGH, STUCK} state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/rc_pulse_meter_if.sv
// Pulse meter signal bundle.
//   sig_in   : raw asynchronous RC pulse input
//   pw       : last measured width in ticks, or a stuck code
//   pw_valid : one-cycle strobe whenever pw is written
// master drives the pin and observes the result; slave is the meter.
interface rc_pulse_meter_if;
  logic        sig_in;
  logic [15:0] pw;
  logic        pw_valid;

  modport master (output sig_in, input pw, input pw_valid);
  modport slave  (input sig_in, output pw, output pw_valid);
endinterface

// File: rtl/rc_glitch_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter.
//   clk, rst : system clock, synchronous active-high reset
//   i_sig    : raw asynchronous input
//   o_level  : filtered level
//   o_rise   : one-cycle pulse, aligned with o_level going high
//   o_fall   : one-cycle pulse, aligned with o_level going low
// Pin-to-level delay is 2 + FILT_LEN clocks for both edges.
module rc_glitch_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_sig};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      // r_cnt counts consecutive samples that disagree with the accepted
      // level; the FILT_LEN-th one flips the level.
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync[1];
          r_rise  <= r_sync[1];
          r_fall  <= ~r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

// File: rtl/rc_pulse_meter.sv
// RC servo pulse width meter with stuck-input detection.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of rc_pulse_meter_if (sig_in in, pw/pw_valid out)
// Width is reported in ticks of TICK_DIV clocks; pulses outside
// MIN_W..MAX_W are dropped silently. No edge for TIMEOUT ticks reports
// PW_STUCK_LOW or PW_STUCK_HIGH once per episode.
//
// state | meaning
// SYNC  | after reset, waiting for a settled low level (drops partial pulse)
// LOW   | input low, waiting for rise
// HIGH  | input high, counting width
// STUCK | stuck code reported, waiting for any edge
module rc_pulse_meter
  import rc_pkg::*;
#(
  parameter int          TICK_DIV = TICK_DIV_DEF,
  parameter int          FILT_LEN = 4,
  parameter logic [15:0] MIN_W    = 16'd150,
  parameter logic [15:0] MAX_W    = 16'd1200,
  parameter logic [15:0] TIMEOUT  = 16'd9600
) (
  input  logic             clk,
  input  logic             rst,
  rc_pulse_meter_if.slave  bus
);
  localparam int PRE_W = (TICK_DIV < 3) ? 1 : $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  // Filter output is meaningless until the pipeline has refilled after
  // reset; a pulse already in progress must not be mistaken for a low.
  localparam int SETTLE = FILT_LEN + 3;
  localparam int ST_W   = $clog2(SETTLE + 1);
  localparam logic [ST_W-1:0] ST_DONE = ST_W'(SETTLE);

  logic w_level, w_rise, w_fall, w_edge, w_tick, w_idle_to, w_settled;
  logic [15:0] w_width_fin;

  state_e           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [15:0]      r_width;
  logic [15:0]      r_idle;
  logic [ST_W-1:0]  r_settle;
  logic [15:0]      r_pw;
  logic             r_pw_valid;

  rc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (bus.sig_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_edge    = w_rise | w_fall;
  assign w_tick    = (r_pre == PRE_MAX);
  assign w_idle_to = (r_idle >= TIMEOUT);
  assign w_settled = (r_settle == ST_DONE);
  // A tick landing in the fall cycle still belongs to the pulse, which
  // makes the result exactly floor(high clocks / TICK_DIV).
  assign w_width_fin = w_tick ? sat_inc(r_width) : r_width;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SYNC;
      r_pre      <= '0;
      r_width    <= '0;
      r_idle     <= '0;
      r_settle   <= '0;
      r_pw       <= PW_STUCK_LOW;
      r_pw_valid <= 1'b0;
    end else begin
      r_pw_valid <= 1'b0;

      r_pre <= (w_edge || w_tick) ? '0 : r_pre + 1'b1;

      if (w_edge)              r_idle <= '0;
      else if (w_tick)         r_idle <= sat_inc(r_idle);

      if (w_edge)              r_width <= '0;
      else if (w_tick && w_level) r_width <= sat_inc(r_width);

      if (!w_settled)          r_settle <= r_settle + 1'b1;

      case (r_state)
        SYNC: begin
          if (w_level && w_idle_to) begin
            r_pw       <= PW_STUCK_HIGH;
            r_pw_valid <= 1'b1;
            r_state    <= STUCK;
          end else if (w_settled && !w_level) begin
            r_state <= LOW;
          end
        end
        LOW: begin
          if (w_rise) begin
            r_state <= HIGH;
          end else if (w_idle_to) begin
            r_pw       <= PW_STUCK_LOW;
            r_pw_valid <= 1'b1;
            r_state    <= STUCK;
          end
        end
        HIGH: begin
          if (w_fall) begin
            if (w_width_fin >= MIN_W && w_width_fin <= MAX_W) begin
              r_pw       <= w_width_fin;
              r_pw_valid <= 1'b1;
            end
            r_state <= LOW;
          end else if (w_idle_to) begin
            r_pw       <= PW_STUCK_HIGH;
            r_pw_valid <= 1'b1;
            r_state    <= STUCK;
          end
        end
        STUCK: begin
          if (w_rise)      r_state <= HIGH;
          else if (w_fall) r_state <= LOW;
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  assign bus.pw       = r_pw;
  assign bus.pw_valid = r_pw_valid;
endmodule

// File: tb/tb_rc_pulse_meter.sv
// Bench for rc_pulse_meter with scaled timing so stuck detection fits
// in a short run: 7 clocks per tick, range 20..300 ticks, timeout 500.
module tb_rc_pulse_meter;
  localparam int          DIV  = 7;
  localparam logic [15:0] MINW = 16'd20;
  localparam logic [15:0] MAXW = 16'd300;
  localparam logic [15:0] TO   = 16'd500;
  localparam int          LAT  = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc_pulse_meter_if bus();

  rc_pulse_meter #(
    .TICK_DIV (DIV),
    .FILT_LEN (4),
    .MIN_W    (MINW),
    .MAX_W    (MAXW),
    .TIMEOUT  (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          fall_cyc;
  int          bad_chg = 0;
  bit          skip_chg = 1'b1;
  logic [15:0] last_pw = 16'h0000;
  logic [15:0] exp_pw  = 16'h0000;
  int          sq_cyc[$];
  logic [15:0] sq_val[$];

  always @(posedge clk) cyc++;

  // Strobe recorder, plus a watch for pw moving without a strobe.
  always @(negedge clk) begin
    if (bus.pw_valid === 1'b1) begin
      sq_cyc.push_back(cyc);
      sq_val.push_back(bus.pw);
    end
    if (!skip_chg && bus.pw !== last_pw && bus.pw_valid !== 1'b1) bad_chg++;
    last_pw = bus.pw;
  end

  // Reference: a high time of n clocks reads floor(n / DIV) ticks.
  function automatic int ref_ticks(input int n);
    return n / DIV;
  endfunction

  function automatic bit ref_ok(input int t);
    return (t >= int'(MINW)) && (t <= int'(MAXW));
  endfunction

  task automatic hold(input logic v, input int n);
    bus.sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pulse(input int n_hi, input int n_lo);
    sq_cyc.delete();
    sq_val.delete();
    hold(1'b1, n_hi);
    fall_cyc = cyc;
    hold(1'b0, n_lo);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.sig_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    sq_cyc.delete();
    sq_val.delete();
    hold(1'b0, 50);
    skip_chg = 1'b0;
    n_chk++;
    if (bus.pw !== 16'h0000) $display("FAIL reset_pw: got %h expected 0000", bus.pw);
    else n_pass++;
    n_chk++;
    if (bus.pw_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.pw_valid);
    else n_pass++;
    n_chk++;
    if (sq_val.size() != 0) $display("FAIL reset_strobes: got %0d expected 0", sq_val.size());
    else n_pass++;
  endtask

  task automatic test_valid_pulse;
    send_pulse(1200, 400);
    n_chk++;
    if (sq_val.size() != 1) $display("FAIL valid_count: got %0d expected 1", sq_val.size());
    else n_pass++;
    if (sq_val.size() > 0) begin
      n_chk++;
      if (sq_val[0] !== 16'(ref_ticks(1200)))
        $display("FAIL valid_pw: got %0d expected %0d", sq_val[0], ref_ticks(1200));
      else n_pass++;
      n_chk++;
      if (sq_cyc[0] - fall_cyc != LAT)
        $display("FAIL valid_latency: got %0d expected %0d", sq_cyc[0] - fall_cyc, LAT);
      else n_pass++;
    end
    exp_pw = 16'(ref_ticks(1200));
  endtask

  task automatic test_random_pulses;
    for (int i = 0; i < 16; i++) begin
      int n, gap, t;
      n   = $urandom_range(60, 2400);
      gap = $urandom_range(100, 900);
      t   = ref_ticks(n);
      send_pulse(n, gap);
      n_chk++;
      if (sq_val.size() != (ref_ok(t) ? 1 : 0))
        $display("FAIL random_count n=%0d: got %0d expected %0d", n, sq_val.size(), ref_ok(t) ? 1 : 0);
      else n_pass++;
      if (ref_ok(t)) begin
        exp_pw = 16'(t);
        if (sq_val.size() > 0) begin
          n_chk++;
          if (sq_val[0] !== exp_pw || sq_cyc[0] - fall_cyc != LAT)
            $display("FAIL random_pw n=%0d: got %0d lat %0d expected %0d lat %0d",
                     n, sq_val[0], sq_cyc[0] - fall_cyc, exp_pw, LAT);
          else n_pass++;
        end
      end
      n_chk++;
      if (bus.pw !== exp_pw) $display("FAIL random_hold n=%0d: got %0d expected %0d", n, bus.pw, exp_pw);
      else n_pass++;
    end
  endtask

  task automatic test_boundaries;
    int lens[6] = '{139, 140, 2100, 2106, 2107, 146};
    foreach (lens[i]) begin
      int t;
      t = ref_ticks(lens[i]);
      send_pulse(lens[i], 300);
      if (ref_ok(t)) exp_pw = 16'(t);
      n_chk++;
      if (sq_val.size() != (ref_ok(t) ? 1 : 0) || bus.pw !== exp_pw)
        $display("FAIL boundary n=%0d: got %0d strobes pw %0d expected %0d strobes pw %0d",
                 lens[i], sq_val.size(), bus.pw, ref_ok(t) ? 1 : 0, exp_pw);
      else n_pass++;
    end
  endtask

  task automatic test_glitch;
    sq_cyc.delete();
    sq_val.delete();
    hold(1'b0, 300);
    hold(1'b1, 3);
    hold(1'b0, 300);
    n_chk++;
    if (sq_val.size() != 0) $display("FAIL glitch_high: got %0d strobes expected 0", sq_val.size());
    else n_pass++;
    hold(1'b1, 600);
    hold(1'b0, 3);
    send_pulse(600, 300);
    n_chk++;
    if (sq_val.size() != 1 || sq_val[0] !== 16'(ref_ticks(1203)))
      $display("FAIL glitch_low: got %0d strobes pw %0d expected 1 strobe pw %0d",
               sq_val.size(), bus.pw, ref_ticks(1203));
    else n_pass++;
    exp_pw = 16'(ref_ticks(1203));
  endtask

  task automatic test_stuck_low;
    send_pulse(1200, 300);
    exp_pw = 16'(ref_ticks(1200));
    sq_cyc.delete();
    sq_val.delete();
    hold(1'b0, 3600);
    n_chk++;
    if (sq_val.size() != 1 || sq_val[0] !== 16'h0000)
      $display("FAIL stuck_low: got %0d strobes pw %h expected 1 strobe pw 0000", sq_val.size(), bus.pw);
    else n_pass++;
    sq_cyc.delete();
    sq_val.delete();
    hold(1'b0, 3600);
    n_chk++;
    if (sq_val.size() != 0 || bus.pw !== 16'h0000)
      $display("FAIL stuck_low_hold: got %0d strobes pw %h expected 0 strobes pw 0000", sq_val.size(), bus.pw);
    else n_pass++;
    send_pulse(1200, 300);
    n_chk++;
    if (sq_val.size() != 1 || bus.pw !== 16'(ref_ticks(1200)))
      $display("FAIL stuck_low_recover: got %0d strobes pw %0d expected 1 strobe pw %0d",
               sq_val.size(), bus.pw, ref_ticks(1200));
    else n_pass++;
    exp_pw = 16'(ref_ticks(1200));
  endtask

  task automatic test_stuck_high;
    sq_cyc.delete();
    sq_val.delete();
    hold(1'b1, 3600);
    n_chk++;
    if (sq_val.size() != 1 || sq_val[0] !== 16'hFFFF)
      $display("FAIL stuck_high: got %0d strobes pw %h expected 1 strobe pw ffff", sq_val.size(), bus.pw);
    else n_pass++;
    sq_cyc.delete();
    sq_val.delete();
    hold(1'b1, 3600);
    hold(1'b0, 300);
    n_chk++;
    if (sq_val.size() != 0 || bus.pw !== 16'hFFFF)
      $display("FAIL stuck_high_hold: got %0d strobes pw %h expected 0 strobes pw ffff", sq_val.size(), bus.pw);
    else n_pass++;
    send_pulse(1200, 300);
    n_chk++;
    if (sq_val.size() != 1 || bus.pw !== 16'(ref_ticks(1200)))
      $display("FAIL stuck_high_recover: got %0d strobes pw %0d expected 1 strobe pw %0d",
               sq_val.size(), bus.pw, ref_ticks(1200));
    else n_pass++;
    exp_pw = 16'(ref_ticks(1200));
  endtask

  task automatic test_out_of_range;
    send_pulse(100, 300);
    n_chk++;
    if (sq_val.size() != 0 || bus.pw !== exp_pw)
      $display("FAIL short_pulse: got %0d strobes pw %0d expected 0 strobes pw %0d", sq_val.size(), bus.pw, exp_pw);
    else n_pass++;
    send_pulse(2500, 300);
    n_chk++;
    if (sq_val.size() != 0 || bus.pw !== exp_pw)
      $display("FAIL long_pulse: got %0d strobes pw %0d expected 0 strobes pw %0d", sq_val.size(), bus.pw, exp_pw);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pulse;
    hold(1'b1, 500);
    skip_chg = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (bus.pw !== 16'h0000 || bus.pw_valid !== 1'b0)
      $display("FAIL midrst_out: got pw %h valid %b expected pw 0000 valid 0", bus.pw, bus.pw_valid);
    else n_pass++;
    exp_pw = 16'h0000;
    send_pulse(700, 300);
    skip_chg = 1'b0;
    n_chk++;
    if (sq_val.size() != 0 || bus.pw !== 16'h0000)
      $display("FAIL midrst_drop: got %0d strobes pw %0d expected 0 strobes pw 0", sq_val.size(), bus.pw);
    else n_pass++;
    send_pulse(1200, 300);
    n_chk++;
    if (sq_val.size() != 1 || bus.pw !== 16'(ref_ticks(1200)))
      $display("FAIL midrst_next: got %0d strobes pw %0d expected 1 strobe pw %0d",
               sq_val.size(), bus.pw, ref_ticks(1200));
    else n_pass++;
    exp_pw = 16'(ref_ticks(1200));
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      int n;
      n = $urandom_range(200, 2000);
      send_pulse(n, 30);
      n_chk++;
      if (sq_val.size() != 1 || sq_val[0] !== 16'(ref_ticks(n)))
        $display("FAIL b2b n=%0d: got %0d strobes pw %0d expected 1 strobe pw %0d",
                 n, sq_val.size(), bus.pw, ref_ticks(n));
      else n_pass++;
      exp_pw = 16'(ref_ticks(n));
    end
    hold(1'b0, 100);
  endtask

  task automatic test_no_silent_change;
    n_chk++;
    if (bad_chg != 0) $display("FAIL silent_change: got %0d changes expected 0", bad_chg);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.sig_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_valid_pulse();
    test_glitch();
    test_random_pulses();
    test_boundaries();
    test_out_of_range();
    test_back_to_back();
    test_stuck_low();
    test_stuck_high();
    test_reset_mid_pulse();
    test_no_silent_change();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
